uart_rx_frame: RTL and testbench

UART_RX_FRAME -- requirements
Module: uart_rx_frame

---
 rtl/uart_rx_frame.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_frame.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with start-bit glitch rejection,
// optional parity, one or two stop bits, break detection and a one-word
// valid/ready output holding register.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   uart_rx    - asynchronous serial line, idle high, LSB first
//   data_out   - received word, held while valid
//   valid      - data_out/status hold a word not yet consumed
//   ready      - consumer accepts the word when valid & ready at a rising edge
//   parity_err - held word failed parity (always 0 when PARITY = 0)
//   frame_err  - held word had a 0 sampled in a stop bit
//   overrun    - one-cycle pulse: a completed frame was dropped
module uart_rx_frame #(
    parameter int CLOCK_SPEED = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,   // 5..9
    parameter int PARITY      = 0,   // 0 none, 1 odd, 2 even
    parameter int STOP_BITS   = 1    // 1..2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int BIT_TICKS = CLOCK_SPEED / BAUD_RATE;
    localparam int CW        = $clog2(BIT_TICKS + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_TICKS / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    // XOR of data and parity bit must equal this for a good odd-parity frame;
    // folding it in makes the error term zero for a correct frame in both modes.
    localparam logic          ODD       = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CW-1:0]        tick;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 fe_acc;

    // Two-flop synchronizer; resets to the idle (high) line level so a reset
    // never looks like a start bit.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tick       <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            fe_acc     <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            // Consumption; a same-cycle completion below overrides this.
            if (valid && ready) valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        tick  <= '0;
                    end
                end

                // Re-check the line half a bit in, rejecting short glitches.
                S_START: begin
                    if (tick == HALF_LAST) begin
                        tick    <= '0;
                        bit_cnt <= '0;
                        par_bad <= 1'b0;
                        fe_acc  <= 1'b0;
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end

                S_DATA: begin
                    if (tick == BIT_LAST) begin
                        tick  <= '0;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (tick == BIT_LAST) begin
                        tick    <= '0;
                        par_bad <= (^shreg) ^ rx_s ^ ODD;
                        state   <= S_STOP;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end

                S_STOP: begin
                    if (tick == BIT_LAST) begin
                        tick <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            // Frame complete: load unless an unconsumed word
                            // is still held, in which case drop and flag.
                            if (!valid || ready) begin
                                data_out   <= shreg;
                                parity_err <= par_bad;
                                frame_err  <= fe_acc | ~rx_s;
                                valid      <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            bit_cnt <= '0;
                            state   <= rx_s ? S_IDLE : S_BREAK;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (!rx_s) fe_acc <= 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end

                // Line held low past the stop bit: wait for it to recover so a
                // break is not mistaken for a stream of zero frames.
                S_BREAK: begin
                    if (rx_s) state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed-vector bench for uart_rx_frame with a
// scoreboard. Three instances cover 8N1, 7E1 and 8N2 at 16 clocks per bit.
// Stimulus pushes expected words into per-instance queues; a monitor pops and
// compares whenever a word is accepted (valid & ready).
module tb_uart_rx_frame;

    localparam int CS = 16;
    localparam int BR = 1;

    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;

    logic [7:0] data_a;
    logic [6:0] data_b;
    logic [7:0] data_c;
    logic valid_a, perr_a, ferr_a, ovr_a;
    logic valid_b, perr_b, ferr_b, ovr_b;
    logic valid_c, perr_c, ferr_c, ovr_c;

    uart_rx_frame #(.CLOCK_SPEED(CS), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .uart_rx(rx_a), .data_out(data_a), .valid(valid_a),
        .ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a));

    uart_rx_frame #(.CLOCK_SPEED(CS), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .uart_rx(rx_b), .data_out(data_b), .valid(valid_b),
        .ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b));

    uart_rx_frame #(.CLOCK_SPEED(CS), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .uart_rx(rx_c), .data_out(data_c), .valid(valid_c),
        .ready(ready_c), .parity_err(perr_c), .frame_err(ferr_c), .overrun(ovr_c));

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int checks    = 0;
    int errors    = 0;
    int ovr_a_cnt = 0;
    int ovr_other = 0;
    int valid_a_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_word(input string who, input exp_t e, input logic [8:0] d,
                              input logic pe, input logic fe);
        check({who, "_data"}, 32'(d), 32'(e.data));
        check({who, "_parity_err"}, 32'(pe), 32'(e.pe));
        check({who, "_frame_err"}, 32'(fe), 32'(e.fe));
    endtask

    task automatic spurious(input string who, input logic [8:0] d);
        checks++;
        errors++;
        $display("FAIL %s_spurious_word: got %0h expected no word", who, d);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (valid_a) valid_a_cycles++;
            if (ovr_a) ovr_a_cnt++;
            if (ovr_b || ovr_c) ovr_other++;
            if (valid_a && ready_a) begin
                if (q_a.size() == 0) spurious("a", {1'b0, data_a});
                else begin
                    e = q_a.pop_front();
                    check_word("a", e, {1'b0, data_a}, perr_a, ferr_a);
                end
            end
            if (valid_b && ready_b) begin
                if (q_b.size() == 0) spurious("b", {2'b0, data_b});
                else begin
                    e = q_b.pop_front();
                    check_word("b", e, {2'b0, data_b}, perr_b, ferr_b);
                end
            end
            if (valid_c && ready_c) begin
                if (q_c.size() == 0) spurious("c", {1'b0, data_c});
                else begin
                    e = q_c.pop_front();
                    check_word("c", e, {1'b0, data_c}, perr_c, ferr_c);
                end
            end
        end
    end

    task automatic drive(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // One bit period: change the line just after an edge, hold 16 clocks.
    task automatic hold_bit(input int sel, input logic v);
        @(posedge clk);
        #1;
        drive(sel, v);
        repeat (15) @(posedge clk);
    endtask

    // par_bit < 0 means no parity bit; stops[i] is stop bit i.
    task automatic send(input int sel, input logic [8:0] data, input int nbits,
                        input int par_bit, input logic [1:0] stops, input int nstops);
        hold_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) hold_bit(sel, data[i]);
        if (par_bit >= 0) hold_bit(sel, par_bit[0]);
        for (int i = 0; i < nstops; i++) hold_bit(sel, stops[i]);
    endtask

    task automatic idle(input int sel, input int n);
        @(posedge clk);
        #1;
        drive(sel, 1'b1);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid_a", 32'(valid_a), 0);
        check("reset_data_a", 32'(data_a), 0);
        check("reset_flags_a", 32'({perr_a, ferr_a, ovr_a}), 0);
        check("reset_valid_b", 32'(valid_b), 0);
        check("reset_valid_c", 32'(valid_c), 0);
        rst_n = 1'b1;
        idle(0, 5);

        // 8N1 0xA5 with ready high: valid exactly one cycle
        valid_a_cycles = 0;
        q_a.push_back('{data: 9'h0A5, pe: 1'b0, fe: 1'b0});
        send(0, 9'h0A5, 8, -1, 2'b01, 1);
        idle(0, 20);
        check("a5_valid_cycles", 32'(valid_a_cycles), 1);

        // 7E1 0x41: parity bit 1 is wrong (two ones in data), 0 is right
        q_b.push_back('{data: 9'h041, pe: 1'b1, fe: 1'b0});
        send(1, 9'h041, 7, 1, 2'b01, 1);
        idle(1, 10);
        q_b.push_back('{data: 9'h041, pe: 1'b0, fe: 1'b0});
        send(1, 9'h041, 7, 0, 2'b01, 1);
        idle(1, 20);

        // Start-bit glitch: 5 low cycles produce nothing, next frame is clean
        valid_a_cycles = 0;
        @(posedge clk);
        #1 rx_a = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx_a = 1'b1;
        repeat (30) @(posedge clk);
        check("glitch_no_valid", 32'(valid_a_cycles), 0);
        q_a.push_back('{data: 9'h03C, pe: 1'b0, fe: 1'b0});
        send(0, 9'h03C, 8, -1, 2'b01, 1);
        idle(0, 20);

        // 8N2 0x0F, second stop bit 0, then line held low (break)
        q_c.push_back('{data: 9'h00F, pe: 1'b0, fe: 1'b1});
        send(2, 9'h00F, 8, -1, 2'b01, 2);
        repeat (40) @(posedge clk);
        check("break_word_delivered", 32'(q_c.size()), 0);
        idle(2, 30);
        q_c.push_back('{data: 9'h05A, pe: 1'b0, fe: 1'b0});
        send(2, 9'h05A, 8, -1, 2'b11, 2);
        idle(2, 20);

        // Overrun: ready low, 0x11 then 0x22 back-to-back
        ready_a   = 1'b0;
        ovr_a_cnt = 0;
        q_a.push_back('{data: 9'h011, pe: 1'b0, fe: 1'b0});
        send(0, 9'h011, 8, -1, 2'b01, 1);
        send(0, 9'h022, 8, -1, 2'b01, 1);
        idle(0, 20);
        check("overrun_pulses", 32'(ovr_a_cnt), 1);
        check("overrun_held_data", 32'(data_a), 32'h11);
        check("overrun_held_valid", 32'(valid_a), 1);
        @(posedge clk);
        #1 ready_a = 1'b1;
        @(posedge clk);
        #1;
        check("consume_valid_drop", 32'(valid_a), 0);
        check("consume_data_hold", 32'(data_a), 32'h11);

        // Reset during data bit 4 of 0x55, then 0x99
        hold_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) hold_bit(0, (i % 2) == 0);
        @(posedge clk);
        #1 rx_a = 1'b1;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("midreset_data_a", 32'(data_a), 0);
        check("midreset_flags_a", 32'({valid_a, perr_a, ferr_a, ovr_a}), 0);
        check("midreset_data_b", 32'(data_b), 0);
        check("midreset_data_c", 32'(data_c), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(0, 20);
        q_a.push_back('{data: 9'h099, pe: 1'b0, fe: 1'b0});
        send(0, 9'h099, 8, -1, 2'b01, 1);
        idle(0, 30);

        // Every expected word must have been consumed
        check("queue_a_empty", 32'(q_a.size()), 0);
        check("queue_b_empty", 32'(q_b.size()), 0);
        check("queue_c_empty", 32'(q_c.size()), 0);
        check("no_other_overrun", 32'(ovr_other), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
